// File: rtl/md_issue_ctrl.sv
// Issue/stall controller for the muldiv unit, sitting in the E stage of a 5-stage MIPS pipeline.
// Latency: an accepted op pulses md_* one cycle later (registered); busy covers MULT_CYCLES/DIV_CYCLES.
// Backpressure: combinational stall holds F/D/E while a mult/div runs and a HI/LO op waits in E.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   e_valid/e_op/e_a/e_b  E-stage instruction and operands (e_op: 1 mult, 2 multu, 3 div,
//                         4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, others none)
//   flush                 E-stage flush, blocks acceptance in the current cycle
//   md_a, md_b            registered operands to muldiv
//   md_mult..md_mtlo      one-cycle op/select pulses to muldiv
//   busy                  high while a mult/div is modelled as running
//   stall                 freeze F/D/E and bubble M
// Optional feature: define MD_DIVZERO_FAST_EN to drop div/divu with a zero divisor
// (no pulse, no busy time).
module md_issue_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        e_valid,
    input  logic [3:0]  e_op,
    input  logic [31:0] e_a,
    input  logic [31:0] e_b,
    input  logic        flush,
    output logic [31:0] md_a,
    output logic [31:0] md_b,
    output logic        md_mult,
    output logic        md_multu,
    output logic        md_div,
    output logic        md_divu,
    output logic        md_mfhi,
    output logic        md_mflo,
    output logic        md_mthi,
    output logic        md_mtlo,
    output logic        busy,
    output logic        stall
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic is_md;
    logic is_start;
    logic is_mul;
    logic skip_div;
    logic accept;

    always_comb begin
        is_md    = e_valid && (e_op >= 4'd1) && (e_op <= 4'd8);
        is_start = e_valid && (e_op >= 4'd1) && (e_op <= 4'd4);
        is_mul   = (e_op == 4'd1) || (e_op == 4'd2);
    end

`ifdef MD_DIVZERO_FAST_EN
    // A zero divisor leaves HI/LO untouched, so the op is swallowed without occupying muldiv.
    assign skip_div = is_start && !is_mul && (e_b == 32'd0);
`else
    assign skip_div = 1'b0;
`endif

    assign stall  = is_md && (state != IDLE) && !flush;
    assign accept = is_md && !stall && !flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            md_a     <= '0;
            md_b     <= '0;
            md_mult  <= 1'b0;
            md_multu <= 1'b0;
            md_div   <= 1'b0;
            md_divu  <= 1'b0;
            md_mfhi  <= 1'b0;
            md_mflo  <= 1'b0;
            md_mthi  <= 1'b0;
            md_mtlo  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            // Pulses last exactly one cycle unless re-armed by a new accept below.
            md_mult  <= 1'b0;
            md_multu <= 1'b0;
            md_div   <= 1'b0;
            md_divu  <= 1'b0;
            md_mfhi  <= 1'b0;
            md_mflo  <= 1'b0;
            md_mthi  <= 1'b0;
            md_mtlo  <= 1'b0;

            if (accept) begin
                md_a <= e_a;
                md_b <= e_b;
                case (e_op)
                    4'd1:    md_mult  <= 1'b1;
                    4'd2:    md_multu <= 1'b1;
                    4'd3:    md_div   <= !skip_div;
                    4'd4:    md_divu  <= !skip_div;
                    4'd5:    md_mfhi  <= 1'b1;
                    4'd6:    md_mflo  <= 1'b1;
                    4'd7:    md_mthi  <= 1'b1;
                    4'd8:    md_mtlo  <= 1'b1;
                    default: ;
                endcase
            end

            case (state)
                IDLE: begin
                    // Reload only from IDLE, so the counter can never wrap.
                    if (accept && is_start && !skip_div) begin
                        state <= RUN;
                        cnt   <= is_mul ? MULT_LD : DIV_LD;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    // A flush here does not abort: the HI/LO write is already committed to muldiv.
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
